// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch sequencer and its return-address stack.
package fetch_pkg;

    localparam int unsigned DEF_D     = 12;
    localparam int unsigned DEF_OW    = 8;
    localparam int unsigned DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_HALT   = 3'd1,
        ACT_RET    = 3'd2,
        ACT_CALL   = 3'd3,
        ACT_JUMP   = 3'd4,
        ACT_BRANCH = 3'd5,
        ACT_INC    = 3'd6
    } action_e;

    // One action per RUN cycle: stall freezes everything, then halt > ret > call > jump > branch > inc.
    function automatic action_e resolve_action(
        input logic stall,
        input logic halt_req,
        input logic ret_en,
        input logic call_en,
        input logic absjump_en,
        input logic branch_en
    );
        action_e act;
        if (stall)           act = ACT_HOLD;
        else if (halt_req)   act = ACT_HALT;
        else if (ret_en)     act = ACT_RET;
        else if (call_en)    act = ACT_CALL;
        else if (absjump_en) act = ACT_JUMP;
        else if (branch_en)  act = ACT_BRANCH;
        else                 act = ACT_INC;
        return act;
    endfunction

endpackage

// File: rtl/fetch_sequencer_ret_stack.sv
// Return-address LIFO: storage is not reset, only the occupancy count, so stale entries are unreachable.
module ret_stack
    import fetch_pkg::*;
#(
    parameter int unsigned W     = DEF_D,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   depth_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   depth_q;
    logic [AW:0]   depth_d;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign wr_idx  = depth_q[AW-1:0];
    // When full, depth_q[AW-1:0] is 0 and the subtraction wraps to DEPTH-1, the true top.
    assign top_idx = depth_q[AW-1:0] - AW'(1);

    always_comb begin
        depth_d = depth_q;
        if (clear_i) begin
            depth_d = '0;
        end else if (push_i && !full_o) begin
            depth_d = depth_q + ONE_C;
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - ONE_C;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && push_i && !full_o) begin
            mem_q[wr_idx] <= din_i;
        end
    end

    assign dout_o  = mem_q[top_idx];
    assign full_o  = (depth_q == DEPTH_C);
    assign empty_o = (depth_q == '0);
    assign depth_o = depth_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Next-PC controller: owns the program counter, sequences IDLE/RUN/HALT and the return-address stack.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned D     = DEF_D,
    parameter int unsigned OW    = DEF_OW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic                     halt_req,
    input  logic                     branch_en,
    input  logic [OW-1:0]            offset,
    input  logic                     absjump_en,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic [D-1:0]             target,
    output logic [D-1:0]             prog_ctr,
    output logic                     running,
    output logic                     done,
    output logic                     stack_err,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam logic [D-1:0] ONE_C = D'(1);

    state_e       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         err_q, err_d;
    action_e      act;

    logic         st_push, st_pop, st_clear;
    logic [D-1:0] st_top;
    logic         st_full, st_empty;
    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_branch;
    logic [D-1:0] offset_ext;

    assign pc_inc     = pc_q + ONE_C;
    assign offset_ext = {{(D - OW){offset[OW-1]}}, offset};
    assign pc_branch  = pc_q + offset_ext;

    always_comb begin
        act = ACT_HOLD;
        if (state_q == RUN) begin
            act = resolve_action(stall, halt_req, ret_en, call_en, absjump_en, branch_en);
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        err_d    = err_q;
        st_push  = 1'b0;
        st_pop   = 1'b0;
        st_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    pc_d     = '0;
                    st_clear = 1'b1;
                end
            end
            RUN: begin
                unique case (act)
                    ACT_HALT: state_d = HALT;
                    ACT_RET: begin
                        if (st_empty) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d   = st_top;
                            st_pop = 1'b1;
                        end
                    end
                    ACT_CALL: begin
                        if (st_full) begin
                            err_d   = 1'b1;
                            state_d = HALT;
                        end else begin
                            st_push = 1'b1;
                            pc_d    = target;
                        end
                    end
                    ACT_JUMP:   pc_d = target;
                    ACT_BRANCH: pc_d = pc_branch;
                    ACT_INC:    pc_d = pc_inc;
                    default:    ;
                endcase
            end
            HALT: begin
                // Restart wipes the stack so a later return cannot reach pre-halt entries.
                if (start) begin
                    state_d  = RUN;
                    pc_d     = '0;
                    err_d    = 1'b0;
                    st_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    ret_stack #(
        .W     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (st_push),
        .pop_i   (st_pop),
        .clear_i (st_clear),
        .din_i   (pc_inc),
        .dout_o  (st_top),
        .full_o  (st_full),
        .empty_o (st_empty),
        .depth_o (depth)
    );

    assign prog_ctr  = pc_q;
    assign running   = (state_q == RUN);
    assign done      = (state_q == HALT);
    assign stack_err = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer: a table of {controls, expected outputs} plus stall/reset sequences.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        halt_req;
  logic        branch_en;
  logic [7:0]  offset;
  logic        absjump_en;
  logic        call_en;
  logic        ret_en;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        running;
  logic        done;
  logic        stack_err;
  logic [2:0]  depth;

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .halt_req   (halt_req),
    .branch_en  (branch_en),
    .offset     (offset),
    .absjump_en (absjump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .stack_err  (stack_err),
    .depth      (depth)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // control bit masks: {reset_n, start, stall, halt, ret, call, jump, branch}
  localparam logic [7:0] R  = 8'h80;
  localparam logic [7:0] S  = 8'h40;
  localparam logic [7:0] ST = 8'h20;
  localparam logic [7:0] H  = 8'h10;
  localparam logic [7:0] RT = 8'h08;
  localparam logic [7:0] CL = 8'h04;
  localparam logic [7:0] J  = 8'h02;
  localparam logic [7:0] B  = 8'h01;

  // expected status: {running, done, stack_err}
  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_RUN  = 3'b100;
  localparam logic [2:0] ST_HALT = 3'b010;
  localparam logic [2:0] ST_ERR  = 3'b011;

  typedef struct {
    logic [7:0]  ctl;
    logic [7:0]  off;
    logic [11:0] tgt;
    logic [11:0] e_pc;
    logic [2:0]  e_st;
    logic [2:0]  e_dep;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  function automatic vec_t mk(input logic [7:0] ctl, input logic [7:0] off, input logic [11:0] tgt,
                              input logic [11:0] e_pc, input logic [2:0] e_st, input logic [2:0] e_dep);
    vec_t v;
    v.ctl = ctl; v.off = off; v.tgt = tgt;
    v.e_pc = e_pc; v.e_st = e_st; v.e_dep = e_dep;
    return v;
  endfunction

  // driver: present one vector at the negedge, check the result at the following negedge
  task automatic apply(input vec_t v, input string tag);
    logic [2:0] got_st;
    reset      = v.ctl[7];
    start      = v.ctl[6];
    stall      = v.ctl[5];
    halt_req   = v.ctl[4];
    ret_en     = v.ctl[3];
    call_en    = v.ctl[2];
    absjump_en = v.ctl[1];
    branch_en  = v.ctl[0];
    offset     = v.off;
    target     = v.tgt;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    got_st = {running, done, stack_err};
    if (prog_ctr !== v.e_pc) begin
      n_miss++;
      $display("FAIL %s vec %0d prog_ctr: got %h want %h", tag, n_vec, prog_ctr, v.e_pc);
    end
    if (got_st !== v.e_st) begin
      n_miss++;
      $display("FAIL %s vec %0d {running,done,stack_err}: got %b want %b", tag, n_vec, got_st, v.e_st);
    end
    if (depth !== v.e_dep) begin
      n_miss++;
      $display("FAIL %s vec %0d depth: got %0d want %0d", tag, n_vec, depth, v.e_dep);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    branch_en = 1'b0; offset = '0; absjump_en = 1'b0; call_en = 1'b0;
    ret_en = 1'b0; target = '0;

    // reset, start, increments
    vecs.push_back(mk(8'h00,   8'h00, 12'h000, 12'h000, ST_IDLE, 3'd0));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'h000, ST_IDLE, 3'd0));
    vecs.push_back(mk(R|J|CL,  8'h00, 12'h123, 12'h000, ST_IDLE, 3'd0));
    vecs.push_back(mk(R|S,     8'h00, 12'h000, 12'h000, ST_RUN,  3'd0));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'h001, ST_RUN,  3'd0));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'h002, ST_RUN,  3'd0));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'h003, ST_RUN,  3'd0));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'h004, ST_RUN,  3'd0));
    // branches with wrap in both directions
    vecs.push_back(mk(R|J,     8'h00, 12'd10,  12'd10,  ST_RUN,  3'd0));
    vecs.push_back(mk(R|B,     8'hFB, 12'h000, 12'd5,   ST_RUN,  3'd0));
    vecs.push_back(mk(R|J,     8'h00, 12'h000, 12'h000, ST_RUN,  3'd0));
    vecs.push_back(mk(R|B,     8'hFF, 12'h000, 12'hFFF, ST_RUN,  3'd0));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'h000, ST_RUN,  3'd0));
    vecs.push_back(mk(R|J,     8'h00, 12'hFFE, 12'hFFE, ST_RUN,  3'd0));
    vecs.push_back(mk(R|B,     8'h7F, 12'h000, 12'h07D, ST_RUN,  3'd0));
    // call / return
    vecs.push_back(mk(R|J,     8'h00, 12'd20,  12'd20,  ST_RUN,  3'd0));
    vecs.push_back(mk(R|CL,    8'h00, 12'd100, 12'd100, ST_RUN,  3'd1));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'd101, ST_RUN,  3'd1));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'd102, ST_RUN,  3'd1));
    vecs.push_back(mk(R,       8'h00, 12'h000, 12'd103, ST_RUN,  3'd1));
    vecs.push_back(mk(R|RT,    8'h00, 12'h000, 12'd21,  ST_RUN,  3'd0));
    // nested calls until overflow, then HALT ignores controls, then restart
    vecs.push_back(mk(R|J,     8'h00, 12'h07D, 12'h07D, ST_RUN,  3'd0));
    vecs.push_back(mk(R|CL,    8'h00, 12'h200, 12'h200, ST_RUN,  3'd1));
    vecs.push_back(mk(R|CL,    8'h00, 12'h300, 12'h300, ST_RUN,  3'd2));
    vecs.push_back(mk(R|CL,    8'h00, 12'h400, 12'h400, ST_RUN,  3'd3));
    vecs.push_back(mk(R|CL,    8'h00, 12'h500, 12'h500, ST_RUN,  3'd4));
    vecs.push_back(mk(R|CL,    8'h00, 12'h600, 12'h500, ST_ERR,  3'd4));
    vecs.push_back(mk(R|J|RT,  8'h00, 12'h123, 12'h500, ST_ERR,  3'd4));
    vecs.push_back(mk(R|S,     8'h00, 12'h000, 12'h000, ST_RUN,  3'd0));
    // return on empty stack
    vecs.push_back(mk(R|RT,    8'h00, 12'h000, 12'h000, ST_ERR,  3'd0));
    vecs.push_back(mk(R|S,     8'h00, 12'h000, 12'h000, ST_RUN,  3'd0));
    // LIFO order
    vecs.push_back(mk(R|CL,    8'h00, 12'h010, 12'h010, ST_RUN,  3'd1));
    vecs.push_back(mk(R|CL,    8'h00, 12'h020, 12'h020, ST_RUN,  3'd2));
    vecs.push_back(mk(R|RT,    8'h00, 12'h000, 12'h011, ST_RUN,  3'd1));
    vecs.push_back(mk(R|RT,    8'h00, 12'h000, 12'h001, ST_RUN,  3'd0));
    // priority: halt > jump, ret > call, call > jump, jump > branch
    vecs.push_back(mk(R|H|J,   8'h00, 12'h777, 12'h001, ST_HALT, 3'd0));
    vecs.push_back(mk(R|S,     8'h00, 12'h000, 12'h000, ST_RUN,  3'd0));
    vecs.push_back(mk(R|CL,    8'h00, 12'h050, 12'h050, ST_RUN,  3'd1));
    vecs.push_back(mk(R|RT|CL, 8'h00, 12'h099, 12'h001, ST_RUN,  3'd0));
    vecs.push_back(mk(R|CL|J,  8'h00, 12'h030, 12'h030, ST_RUN,  3'd1));
    vecs.push_back(mk(R|J|B,   8'h05, 12'h040, 12'h040, ST_RUN,  3'd1));

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i], "table");

    // stall with call/halt pending freezes everything for three cycles
    apply(mk(R|ST|CL,   8'h00, 12'h123, 12'h040, ST_RUN, 3'd1), "stall");
    apply(mk(R|ST|CL|H, 8'h00, 12'h123, 12'h040, ST_RUN, 3'd1), "stall");
    apply(mk(R|ST|RT,   8'h00, 12'h123, 12'h040, ST_RUN, 3'd1), "stall");
    apply(mk(R,         8'h00, 12'h000, 12'h041, ST_RUN, 3'd1), "stall_release");

    // reset mid-call with depth 2, then verify the stack holds no stale entries
    apply(mk(R|CL,      8'h00, 12'h060, 12'h060, ST_RUN,  3'd2), "pre_reset");
    apply(mk(CL|ST,     8'h00, 12'h070, 12'h000, ST_IDLE, 3'd0), "reset_mid");
    apply(mk(R|S,       8'h00, 12'h000, 12'h000, ST_RUN,  3'd0), "restart");
    apply(mk(R|RT,      8'h00, 12'h000, 12'h000, ST_ERR,  3'd0), "stale_ret");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Next-PC controller owning the program counter register for the core.
- Sequences fetch from start to halt and resolves control flow each cycle: increment, relative branch, absolute jump, call, return.
- Holds a small hardware return-address stack.
- Sits between the decode/control unit (control requests) and instruction memory (prog_ctr address).

Parameters:
D, 12, program counter / address width
OW, 8, width of signed relative branch offset
DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-low reset (reset=0 resets on posedge clk)
start  input  1  begin execution (from IDLE or HALT)
stall  input  1  hold all state this cycle
halt_req  input  1  stop execution after current instruction
branch_en  input  1  relative branch taken
offset  input  OW  signed branch offset, two's complement
absjump_en  input  1  absolute jump
call_en  input  1  absolute jump, push return address
ret_en  input  1  pop return address into PC
target  input  D  absolute jump/call destination
prog_ctr  output  D  current fetch address
running  output  1  state==RUN
done  output  1  state==HALT
stack_err  output  1  sticky: call on full or ret on empty
depth  output  $clog2(DEPTH)+1  current stack occupancy

Behaviour:
- Reset (reset=0 at posedge): state=IDLE, prog_ctr=0, depth=0, stack_err=0, running=0, done=0. Reset overrides every other input, including mid-call and mid-stall.
- IDLE state:
  - prog_ctr held at 0; all control inputs ignored.
  - start=1 -> RUN next cycle; prog_ctr stays 0 on the first RUN cycle.
- RUN state, stall=1: prog_ctr, stack, depth and state all held; every other input ignored, including halt_req.
- RUN state, stall=0: one action per cycle, evaluated in priority order halt_req > ret_en > call_en > absjump_en > branch_en > increment.
  - halt_req: prog_ctr held, state -> HALT.
  - ret_en, depth>0: prog_ctr <= top of stack; depth decrements.
  - ret_en, depth==0: stack_err<=1; prog_ctr held; state -> HALT.
  - call_en, depth<DEPTH: push prog_ctr+1 (mod 2^D); prog_ctr <= target; depth increments.
  - call_en, depth==DEPTH: stack_err<=1; no push; prog_ctr held; state -> HALT.
  - absjump_en: prog_ctr <= target.
  - branch_en: prog_ctr <= prog_ctr + sign_extend(offset) mod 2^D. Wraps in both directions.
  - none asserted: prog_ctr <= prog_ctr+1 mod 2^D. 2^D-1 wraps to 0.
- HALT state:
  - prog_ctr, stack and stack_err held; control inputs ignored.
  - start=1 -> RUN next cycle with prog_ctr=0, depth=0, stack_err=0.
- Latency: every action is visible on prog_ctr the cycle after the request edge. Outputs are registered or decoded from registered state only; no combinational input-to-output path.
- running and done are mutually exclusive; both are 0 in IDLE.
- Stack storage contents are not reset; only depth is. A pop must never return an entry not pushed since the last reset or start.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, HALT}
  - default D/OW/DEPTH constants
  - action enum for the resolved priority (ACT_HOLD, ACT_HALT, ACT_RET, ACT_CALL, ACT_JUMP, ACT_BRANCH, ACT_INC)
- One sub-module ret_stack:
  - parameterised LIFO (width D, DEPTH entries)
  - inputs push, pop, clear, din
  - outputs dout (top), full, empty, depth
  - push and pop are never asserted together by the parent

Test Plan:
- Reset, start, 5 idle cycles -> prog_ctr sequence 0,0,1,2,3,4; running=1; done=0.
- At pc=10: branch_en, offset=8'hFB (-5) -> pc=5. At pc=0: offset=-1 -> pc=12'hFFF. At 12'hFFF: increment -> 0.
- At pc=20: call_en, target=100 -> pc=100, depth=1. Run 3 increments, then ret_en -> pc=21, depth=0.
- Five nested calls with DEPTH=4 -> depth saturates at 4; 5th call sets stack_err=1, done=1, pc held. start -> pc=0, depth=0, stack_err=0.
- ret_en with depth=0 -> stack_err=1, HALT. In RUN, stall=1 with call_en=1 for 3 cycles -> pc and depth unchanged. halt_req together with absjump_en -> HALT, pc unchanged.
- Assert reset=0 for 1 cycle with depth=2, in RUN -> IDLE, pc=0, depth=0. Then start, then ret_en -> stack_err=1 (no stale entries).
